// File: rtl/riscv_core_mul_ctrl.sv
// Sequencing controller for the RV64 M-extension multiply path: accepts one request,
// hands unsigned magnitudes to a fixed-latency array and holds sign flags for correction.
module riscv_core_mul_ctrl #(
  parameter int XLEN        = 64,
  parameter int MUL_LATENCY = 2   // legal range 1..15
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_mul_valid,
  output logic            o_mul_ready,
  input  logic [XLEN-1:0] i_mul_srcA,
  input  logic [XLEN-1:0] i_mul_srcB,
  input  logic [1:0]      i_mul_control,
  input  logic            i_mul_isword,
  input  logic            i_mul_flush,
  output logic            o_mul_start,
  output logic [XLEN-1:0] o_mul_opA,
  output logic [XLEN-1:0] o_mul_opB,
  output logic            o_mul_srcA_Dsign,
  output logic            o_mul_srcB_Dsign,
  output logic            o_mul_srcA_Wsign,
  output logic            o_mul_srcB_Wsign,
  output logic [1:0]      o_mul_control,
  output logic            o_mul_isword,
  output logic            o_mul_result_valid,
  input  logic            i_mul_result_ready,
  output logic            o_mul_busy
);

  localparam int HALF = XLEN / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            a_dsign;
    logic            b_dsign;
    logic            a_wsign;
    logic            b_wsign;
    logic [1:0]      control;
    logic            isword;
  } op_t;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       start_q, start_d;
  op_t        op_q, op_d, op_new;
  logic       accept;
  logic       load;

  // Two's-complement magnitude; the most negative value maps to 2^(w-1) unsigned.
  function automatic logic [XLEN-1:0] mag_d(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? (~x + XLEN'(1)) : x;
  endfunction

  function automatic logic [HALF-1:0] mag_w(input logic [HALF-1:0] x);
    return x[HALF-1] ? (~x + HALF'(1)) : x;
  endfunction

  // Operand conditioning for the incoming request.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    op_new         = '0;
    op_new.op_a    = i_mul_srcA;
    op_new.op_b    = i_mul_srcB;
    op_new.control = i_mul_control;
    op_new.isword  = i_mul_isword;
    if (i_mul_isword) begin
      op_new.op_a = {{HALF{1'b0}}, i_mul_srcA[HALF-1:0]};
      op_new.op_b = {{HALF{1'b0}}, i_mul_srcB[HALF-1:0]};
      if (i_mul_control == 2'b00) begin
        op_new.op_a    = {{HALF{1'b0}}, mag_w(i_mul_srcA[HALF-1:0])};
        op_new.op_b    = {{HALF{1'b0}}, mag_w(i_mul_srcB[HALF-1:0])};
        op_new.a_wsign = i_mul_srcA[HALF-1];
        op_new.b_wsign = i_mul_srcB[HALF-1];
      end
    end else begin
      unique case (i_mul_control)
        2'b00, 2'b01: begin
          op_new.op_a    = mag_d(i_mul_srcA);
          op_new.op_b    = mag_d(i_mul_srcB);
          op_new.a_dsign = i_mul_srcA[XLEN-1];
          op_new.b_dsign = i_mul_srcB[XLEN-1];
        end
        2'b10: begin
          op_new.op_a    = mag_d(i_mul_srcA);
          op_new.a_dsign = i_mul_srcA[XLEN-1];
        end
        default: ;
      endcase
    end
  end

  assign o_mul_ready = (state_q == S_IDLE) ||
                       ((state_q == S_DONE) && i_mul_result_ready);
  assign accept      = i_mul_valid && o_mul_ready && !i_mul_flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) load = 1'b1;
      end
      S_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DONE;
      end
      S_DONE: begin
        if (i_mul_result_ready) begin
          if (accept) load = 1'b1;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d = S_EXEC;
      cnt_d   = 4'(MUL_LATENCY);
      start_d = 1'b1;
    end
    // Flush outranks both a new accept and the result handshake.
    if (i_mul_flush) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      start_d = 1'b0;
    end
  end

  // Operand/flag registers move only on accept, so they stay stable through DONE.
  assign op_d = load ? op_new : op_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      start_q <= 1'b0;
      op_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      op_q    <= op_d;
    end
  end

  assign o_mul_start        = start_q;
  assign o_mul_opA          = op_q.op_a;
  assign o_mul_opB          = op_q.op_b;
  assign o_mul_srcA_Dsign   = op_q.a_dsign;
  assign o_mul_srcB_Dsign   = op_q.b_dsign;
  assign o_mul_srcA_Wsign   = op_q.a_wsign;
  assign o_mul_srcB_Wsign   = op_q.b_wsign;
  assign o_mul_control      = op_q.control;
  assign o_mul_isword       = op_q.isword;
  assign o_mul_result_valid = (state_q == S_DONE);
  assign o_mul_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_riscv_core_mul_ctrl.sv
// Directed bench for riscv_core_mul_ctrl with hand-computed expectations (XLEN=64, latency 2).
module tb_riscv_core_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, ready;
  logic [63:0] src_a, src_b;
  logic [1:0]  ctrl;
  logic        isword, flush;
  logic        start;
  logic [63:0] op_a, op_b;
  logic        a_ds, b_ds, a_ws, b_ws;
  logic [1:0]  ctrl_o;
  logic        isword_o;
  logic        rv, rr, busy;

  int total = 0;
  int bad   = 0;

  riscv_core_mul_ctrl #(.XLEN(64), .MUL_LATENCY(2)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_mul_valid        (valid),
    .o_mul_ready        (ready),
    .i_mul_srcA         (src_a),
    .i_mul_srcB         (src_b),
    .i_mul_control      (ctrl),
    .i_mul_isword       (isword),
    .i_mul_flush        (flush),
    .o_mul_start        (start),
    .o_mul_opA          (op_a),
    .o_mul_opB          (op_b),
    .o_mul_srcA_Dsign   (a_ds),
    .o_mul_srcB_Dsign   (b_ds),
    .o_mul_srcA_Wsign   (a_ws),
    .o_mul_srcB_Wsign   (b_ws),
    .o_mul_control      (ctrl_o),
    .o_mul_isword       (isword_o),
    .o_mul_result_valid (rv),
    .i_mul_result_ready (rr),
    .o_mul_busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] c, input logic w);
    valid  = 1'b1;
    src_a  = a;
    src_b  = b;
    ctrl   = c;
    isword = w;
  endtask

  task automatic wait_rv(input string tag);
    int n = 0;
    while (!rv && n < 20) begin
      step();
      n++;
    end
    check(tag, {63'd0, rv}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; src_a = '0; src_b = '0;
    ctrl = 2'b00; isword = 1'b0; flush = 1'b0; rr = 1'b0;
    #3;
    check("rst_busy",  {63'd0, busy},  64'd0);
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_start", {63'd0, start}, 64'd0);
    check("rst_rv",    {63'd0, rv},    64'd0);
    check("rst_opA",   op_a,           64'd0);
    #9 rst_n = 1'b1;
    step();
    step();

    // MUL -3 * 5: accept in cycle 0, start in cycle 1, result_valid in cycle 3
    drive(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 2'b00, 1'b0);
    check("mul_ready_c0", {63'd0, ready}, 64'd1);
    step();
    valid = 1'b0;
    check("mul_start_c1", {63'd0, start}, 64'd1);
    check("mul_opA",      op_a,           64'd3);
    check("mul_opB",      op_b,           64'd5);
    check("mul_dsA",      {63'd0, a_ds},  64'd1);
    check("mul_dsB",      {63'd0, b_ds},  64'd0);
    check("mul_ws",       {62'd0, a_ws, b_ws}, 64'd0);
    check("mul_busy_c1",  {63'd0, busy},  64'd1);
    check("mul_rv_c1",    {63'd0, rv},    64'd0);
    step();
    check("mul_start_c2", {63'd0, start}, 64'd0);
    check("mul_rv_c2",    {63'd0, rv},    64'd0);
    step();
    check("mul_rv_c3",    {63'd0, rv},    64'd1);
    check("mul_ready_c3", {63'd0, ready}, 64'd0);
    step();
    check("mul_rv_hold",  {63'd0, rv},    64'd1);
    check("mul_opA_hold", op_a,           64'd3);
    rr = 1'b1;
    #1 check("mul_ready_rr", {63'd0, ready}, 64'd1);
    step();
    rr = 1'b0;
    check("mul_idle_busy", {63'd0, busy}, 64'd0);
    check("mul_idle_rv",   {63'd0, rv},   64'd0);

    // MULHSU -1 * 0x8000.., then MULW back-to-back from DONE
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b10, 1'b0);
    step();
    valid = 1'b0;
    wait_rv("hsu_rv_wait");
    check("hsu_opA", op_a,          64'd1);
    check("hsu_opB", op_b,          64'h8000_0000_0000_0000);
    check("hsu_dsA", {63'd0, a_ds}, 64'd1);
    check("hsu_dsB", {63'd0, b_ds}, 64'd0);
    check("hsu_ctl", {62'd0, ctrl_o}, 64'd2);
    rr = 1'b1;
    drive(64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 2'b00, 1'b1);
    #1 check("b2b_ready", {63'd0, ready}, 64'd1);
    step();
    rr = 1'b0;
    valid = 1'b0;
    check("b2b_start",  {63'd0, start},    64'd1);
    check("b2b_busy",   {63'd0, busy},     64'd1);
    check("b2b_rv",     {63'd0, rv},       64'd0);
    check("mulw_opA",   op_a,              64'h0000_0000_8000_0000);
    check("mulw_opB",   op_b,              64'd1);
    check("mulw_ws",    {62'd0, a_ws, b_ws}, 64'd3);
    check("mulw_ds",    {62'd0, a_ds, b_ds}, 64'd0);
    check("mulw_isw",   {63'd0, isword_o}, 64'd1);
    wait_rv("mulw_rv_wait");
    rr = 1'b1;
    step();
    rr = 1'b0;

    // MULHU passes raw operands; word MULH passes raw low half with no flags
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b11, 1'b0);
    step();
    valid = 1'b0;
    check("hu_opA", op_a, 64'hFFFF_FFFF_FFFF_FFFF);
    check("hu_flags", {60'd0, a_ds, b_ds, a_ws, b_ws}, 64'd0);
    wait_rv("hu_rv_wait");
    rr = 1'b1;
    drive(64'hFFFF_FFFF_8000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 2'b01, 1'b1);
    step();
    rr = 1'b0;
    valid = 1'b0;
    check("wh_opA", op_a, 64'h0000_0000_8000_0001);
    check("wh_opB", op_b, 64'h0000_0000_FFFF_FFFE);
    check("wh_flags", {60'd0, a_ds, b_ds, a_ws, b_ws}, 64'd0);
    wait_rv("wh_rv_wait");
    rr = 1'b1;
    step();
    rr = 1'b0;

    // Flush in EXEC cycle 2
    drive(64'd7, 64'd9, 2'b00, 1'b0);
    step();
    valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_exec_busy", {63'd0, busy}, 64'd0);
    check("fl_exec_rv",   {63'd0, rv},   64'd0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        seen |= rv;
        step();
      end
      check("fl_exec_no_rv", {63'd0, seen}, 64'd0);
    end

    // Flush alongside a valid request in IDLE drops the request
    drive(64'd11, 64'd13, 2'b00, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    valid = 1'b0;
    check("fl_idle_busy",  {63'd0, busy},  64'd0);
    check("fl_idle_start", {63'd0, start}, 64'd0);
    step();
    check("fl_idle_rv",    {63'd0, rv},    64'd0);

    // Asynchronous reset in the middle of EXEC
    drive(64'd4, 64'd6, 2'b00, 1'b0);
    step();
    valid = 1'b0;
    check("rm_start_pre", {63'd0, start}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rm_busy",  {63'd0, busy},  64'd0);
    check("rm_start", {63'd0, start}, 64'd0);
    check("rm_rv",    {63'd0, rv},    64'd0);
    #2 rst_n = 1'b1;
    step();
    check("rm_ready", {63'd0, ready}, 64'd1);
    check("rm_idle",  {63'd0, busy},  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_core_mul_ctrl.md
Name: riscv_core_mul_ctrl

Overview:
Sequencing controller for the RV64 M-extension multiply path, sitting between the execute-stage issue logic and the unsigned fixed-latency multiplier array. It accepts one MUL/MULH/MULHSU/MULHU/MULW request per handshake and converts the operands to unsigned magnitudes. It launches the array and counts its latency. It registers the sign and control flags that the multiplier output/sign-correction stage needs, then presents a result-valid handshake and holds the pipeline busy while it waits.

Parameters:
XLEN, 64, datapath width; word ops use the low XLEN/2 bits.
MUL_LATENCY, 2, cycles from the o_mul_start cycle to a valid array product; legal range 1..15.

Ports:
i_clk  in  1  core clock.
i_rst_n  in  1  asynchronous active-low reset.
i_mul_valid  in  1  request valid from execute.
o_mul_ready  out  1  controller can accept a request this cycle.
i_mul_srcA  in  XLEN  operand A (rs1).
i_mul_srcB  in  XLEN  operand B (rs2).
i_mul_control  in  2  00 MUL/MULW, 01 MULH, 10 MULHSU, 11 MULHU.
i_mul_isword  in  1  word (W) op.
i_mul_flush  in  1  pipeline flush; aborts the current op.
o_mul_start  out  1  one-cycle launch pulse to the array.
o_mul_opA  out  XLEN  unsigned magnitude of A to the array.
o_mul_opB  out  XLEN  unsigned magnitude of B to the array.
o_mul_srcA_Dsign  out  1  A doubleword sign flag for the output stage.
o_mul_srcB_Dsign  out  1  B doubleword sign flag.
o_mul_srcA_Wsign  out  1  A word sign flag.
o_mul_srcB_Wsign  out  1  B word sign flag.
o_mul_control  out  2  registered i_mul_control.
o_mul_isword  out  1  registered i_mul_isword.
o_mul_result_valid  out  1  array product is valid and the flags are aligned.
i_mul_result_ready  in  1  writeback accepts the result.
o_mul_busy  out  1  state != IDLE, used as the stall request.

Behaviour:
- Reset is asynchronous on i_rst_n low: state IDLE, counter 0, and all outputs 0 (ready is combinational and reads 1 in IDLE).
- States:
  - IDLE: ready=1. On accept (valid&&ready&&!flush), register the operands and flags, load counter=MUL_LATENCY, go to EXEC.
  - EXEC: o_mul_start=1 only in the first EXEC cycle. Counter decrements each cycle; at counter==1 go to DONE.
  - DONE: o_mul_result_valid=1 and held with its flags stable until i_mul_result_ready.
- Timing: accept at edge of cycle 0; start is high in cycle 1; result_valid is high in cycle 1+MUL_LATENCY.
- DONE with i_mul_result_ready: ready=1 in the same cycle, allowing back-to-back issue. If a new request is accepted, go to EXEC with the new registers; otherwise go to IDLE.
- o_mul_ready = IDLE || (DONE && i_mul_result_ready).
- Magnitude: |x| = x[MSB] ? (~x+1) : x, truncated to width; the most negative value maps to 2^(w-1) unsigned.
- Operands and flags per operation (non-word):
  - MUL, MULH: DsignA=A[63], DsignB=B[63]; both operands take magnitudes.
  - MULHSU: DsignA=A[63], DsignB=0; only A takes a magnitude.
  - MULHU: both flags 0; raw operands.
- Word ops (isword=1): opA/opB = zero-extended |low 32 bits| for control 00. Wsign=A[31]/B[31]. Dsign flags are 0. Word ops with control!=00 pass the low 32 bits raw with all flags 0.
- Non-word ops drive both Wsign flags to 0.
- Flush: i_mul_flush in any state returns to IDLE next edge, clears start and result_valid, and drops a request offered the same cycle. Flush has priority over accept and over result_ready.
- Operand, flag and control outputs change only on accept; they are stable from start through the DONE handshake.
- Only one op is in flight; the array is never restarted before DONE is consumed or a flush occurs.

Test Plan:
- Reset mid-EXEC: assert i_rst_n low asynchronously -> busy, start and result_valid fall to 0 immediately; ready=1 after release.
- MUL A=-3 (0xFFFF_FFFF_FFFF_FFFD), B=5, MUL_LATENCY=2 -> opA=3, opB=5, DsignA=1, DsignB=0, start in cycle 1, result_valid in cycle 3.
- MULHSU A=-1, B=0x8000_0000_0000_0000 -> opA=1, opB=0x8000_0000_0000_0000, DsignA=1, DsignB=0.
- MULW A=0x1_8000_0000, B=0xFFFF_FFFF -> opA=0x8000_0000, opB=1, Wsign=1/1, Dsign=0/0, isword=1.
- Back-to-back: result_ready=1 and a new valid in DONE -> new op accepted the same cycle, start in the next cycle, no idle gap.
- Flush in EXEC cycle 2, and separately flush with valid in IDLE -> no result_valid ever asserted, state IDLE, busy=0 the next cycle.
